// File: rtl/stitch_sb_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stitch_sb_mp_if                                                 |
// | Brief    : Push / multi-pop / hazard-test bundle for stitch_sb_mp.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface stitch_sb_mp_if #(
  parameter int AddrWidth    = 5,
  parameter int Depth        = 4,
  parameter int NumPop       = 2,
  parameter int NumTestAddrs = 3
);
  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic                                   flush_i;
  logic [AddrWidth-1:0]                   push_addr_i;
  logic                                   push_valid_i;
  logic                                   push_ready_o;
  logic [IdxW-1:0]                        push_index_o;
  logic [NumPop-1:0][IdxW-1:0]            pop_index_i;
  logic [NumPop-1:0]                      pop_valid_i;
  logic [NumTestAddrs-1:0][AddrWidth-1:0] test_addr_i;
  logic [NumTestAddrs-1:0]                test_addr_present_o;
  logic                                   full_o;
  logic                                   empty_o;
  logic [CntW-1:0]                        usage_o;

  modport slave (
    input  flush_i, push_addr_i, push_valid_i, pop_index_i, pop_valid_i, test_addr_i,
    output push_ready_o, push_index_o, test_addr_present_o, full_o, empty_o, usage_o
  );

  modport master (
    output flush_i, push_addr_i, push_valid_i, pop_index_i, pop_valid_i, test_addr_i,
    input  push_ready_o, push_index_o, test_addr_present_o, full_o, empty_o, usage_o
  );
endinterface
`default_nettype wire

// File: rtl/stitch_sb_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stitch_sb_mp                                                    |
// | Brief    : Pending-write scoreboard with multi-port release and hazard     |
// |            test ports; allocation state is the valid-bit vector alone.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stitch_sb_mp #(
  parameter int AddrWidth    = 5,
  parameter int Depth        = 4,
  parameter int NumPop       = 2,
  parameter int NumTestAddrs = 3,
  parameter int PopBypass    = 1,
  parameter int IgnoreZero   = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  stitch_sb_mp_if.slave  bus
);
  // Interface instance must carry the same AddrWidth/Depth/NumPop/NumTestAddrs.
  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Depth-1:0]     r_valid;
  logic [AddrWidth-1:0] r_addr [Depth];

  logic [IdxW-1:0]         w_free_idx;
  logic                    w_found;
  logic [Depth-1:0]        w_pop_mask;
  logic [Depth-1:0]        w_masked;
  logic [Depth-1:0]        w_push_onehot;
  logic [CntW-1:0]         w_usage;
  logic                    w_full;
  logic                    w_push_fire;
  logic [NumTestAddrs-1:0] w_present;

  always_comb begin
    w_free_idx = '0;
    w_found    = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (!r_valid[i] && !w_found) begin
        w_free_idx = IdxW'(i);
        w_found    = 1'b1;
      end
    end
  end

  // Pops matching no valid entry, or naming an index beyond Depth, select nothing.
  always_comb begin
    w_pop_mask = '0;
    for (int i = 0; i < Depth; i++) begin
      for (int k = 0; k < NumPop; k++) begin
        if (bus.pop_valid_i[k] && (bus.pop_index_i[k] == IdxW'(i))) begin
          w_pop_mask[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_usage = '0;
    for (int i = 0; i < Depth; i++) begin
      w_usage = w_usage + CntW'(r_valid[i]);
    end
  end

  assign w_full      = (w_usage == CntW'(Depth));
  assign w_push_fire = bus.push_valid_i && !w_full;

  always_comb begin
    w_push_onehot = '0;
    for (int i = 0; i < Depth; i++) begin
      w_push_onehot[i] = w_push_fire && (w_free_idx == IdxW'(i));
    end
  end

  if (PopBypass != 0) begin : g_bypass
    assign w_masked = w_pop_mask;
  end else begin : g_no_bypass
    assign w_masked = '0;
  end

  // Push target is always an invalid entry, so applying the push after the pop never loses it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (bus.flush_i) begin
      r_valid <= '0;
    end else begin
      r_valid <= (r_valid & ~w_pop_mask) | w_push_onehot;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      if (w_push_onehot[i] && !bus.flush_i && !rst_i) begin
        r_addr[i] <= bus.push_addr_i;
      end
    end
  end

  always_comb begin
    w_present = '0;
    for (int j = 0; j < NumTestAddrs; j++) begin
      for (int i = 0; i < Depth; i++) begin
        if (r_valid[i] && !w_masked[i] && (r_addr[i] == bus.test_addr_i[j])) begin
          w_present[j] = 1'b1;
        end
      end
      if ((IgnoreZero != 0) && (bus.test_addr_i[j] == '0)) begin
        w_present[j] = 1'b0;
      end
    end
  end

  assign bus.test_addr_present_o = w_present;
  assign bus.push_index_o        = w_free_idx;
  assign bus.usage_o             = w_usage;
  assign bus.full_o              = w_full;
  assign bus.empty_o             = (w_usage == '0);
  assign bus.push_ready_o        = !w_full;

endmodule
`default_nettype wire
